// File: rtl/ifu_inst_buffer.sv
// Instruction FIFO between fetch and decode; issues NOP bubbles when there is nothing to issue.
// Optional IBUF_BYPASS_EN: an empty buffer forwards the incoming fetch beat to decode in the same cycle.
module ifu_inst_buffer #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     inst_valid_i,
  output logic                     inst_ready_o,
  input  logic [INST_W-1:0]        inst_i,
  input  logic [ADDR_W-1:0]        inst_addr_i,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic [INST_W-1:0]        inst_o,
  output logic [ADDR_W-1:0]        inst_addr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

  logic [INST_W-1:0] r_inst [DEPTH];
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW-1:0]     r_count;
  logic [PW-1:0]     w_wptr_nxt;
  logic [PW-1:0]     w_rptr_nxt;
  logic              w_empty;
  logic              w_full;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;

  assign w_empty      = (r_wptr == r_rptr);
  assign w_full       = (r_wptr[PW-2:0] == r_rptr[PW-2:0]) & (r_wptr[PW-1] != r_rptr[PW-1]);
  // Ready deliberately ignores a same-cycle pop, so id_ready_i never reaches inst_ready_o.
  assign inst_ready_o = ~w_full & ~flush_i;

`ifdef IBUF_BYPASS_EN
  assign w_bypass = w_empty & ~flush_i & inst_valid_i;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed beat that decode takes immediately is never written.
  assign w_push = inst_valid_i & inst_ready_o & ~(w_bypass & id_ready_i);
  assign w_pop  = ~w_empty & ~flush_i & id_ready_i;

  assign w_wptr_nxt = r_wptr + PW'(w_push);
  assign w_rptr_nxt = r_rptr + PW'(w_pop);

  always_comb begin
    id_valid_o  = 1'b0;
    inst_o      = NOP;
    inst_addr_o = '0;
    if (w_bypass) begin
      id_valid_o  = 1'b1;
      inst_o      = inst_i;
      inst_addr_o = inst_addr_i;
    end else if (~w_empty & ~flush_i) begin
      id_valid_o  = 1'b1;
      inst_o      = r_inst[r_rptr[PW-2:0]];
      inst_addr_o = r_addr[r_rptr[PW-2:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_wptr_nxt - w_rptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst[r_wptr[PW-2:0]] <= inst_i;
      r_addr[r_wptr[PW-2:0]] <= inst_addr_i;
    end
  end

  assign count_o = r_count;

endmodule

// File: tb/tb_ifu_inst_buffer.sv
// Directed bench for ifu_inst_buffer (DEPTH=4): vector table plus reset/bypass sequences.
module tb_ifu_inst_buffer;

`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        inst_valid_i = 1'b0;
  logic        inst_ready_o;
  logic [31:0] inst_i = '0;
  logic [31:0] inst_addr_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [2:0]  count_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  ifu_inst_buffer #(.DEPTH(4), .INST_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fl; logic v; int k; logic rd;
    logic eidv; int ek; logic erdy; int ecnt;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] mk_inst(int k);
    return 32'h0050_0093 + (32'(k) << 12);
  endfunction
  function automatic logic [31:0] mk_addr(int k);
    return 32'h8000_0000 + 32'(4 * k);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(logic fl, logic v, int k, logic rd, logic eidv, int ek, logic erdy, int ecnt);
    vec_t t;
    t.fl = fl; t.v = v; t.k = k; t.rd = rd;
    t.eidv = eidv; t.ek = ek; t.erdy = erdy; t.ecnt = ecnt;
    tbl.push_back(t);
  endtask

  task automatic drive(logic fl, logic v, int k, logic rd);
    @(negedge clk);
    flush_i = fl; inst_valid_i = v; id_ready_i = rd;
    inst_i = mk_inst(k); inst_addr_i = mk_addr(k);
    #2;
  endtask

  task automatic check_out(string tag, logic eidv, int ek, logic erdy, int ecnt);
    chk({tag, " id_valid"}, 32'(id_valid_o), 32'(eidv));
    chk({tag, " inst"}, inst_o, (ek < 0) ? NOP : mk_inst(ek));
    chk({tag, " addr"}, inst_addr_o, (ek < 0) ? 32'h0 : mk_addr(ek));
    chk({tag, " ready"}, 32'(inst_ready_o), 32'(erdy));
    chk({tag, " count"}, 32'(count_o), 32'(ecnt));
  endtask

  initial begin
    // fl v k rd | idv ek rdy cnt   (ek = -1 means NOP bubble)
    add(0, 0, 0, 0, 0, -1, 1, 0);
    add(0, 1, 0, 0, BYP, BYP ? 0 : -1, 1, 0);
    add(0, 1, 1, 0, 1, 0, 1, 1);
    add(0, 1, 2, 0, 1, 0, 1, 2);
    add(0, 1, 3, 0, 1, 0, 1, 3);
    add(0, 0, 0, 0, 1, 0, 0, 4);
    add(0, 1, 4, 1, 1, 0, 0, 4);  // full: beat 4 refused, A popped
    add(0, 1, 4, 0, 1, 1, 1, 3);
    add(0, 0, 0, 1, 1, 1, 0, 4);
    add(0, 0, 0, 1, 1, 2, 1, 3);
    add(0, 0, 0, 1, 1, 3, 1, 2);
    add(0, 0, 0, 1, 1, 4, 1, 1);
    add(0, 0, 0, 0, 0, -1, 1, 0);
    add(0, 1, 5, 0, BYP, BYP ? 5 : -1, 1, 0);
    add(0, 1, 6, 0, 1, 5, 1, 1);
    for (int j = 0; j < 10; j++) add(0, 1, 7 + j, 1, 1, 5 + j, 1, 2);
    add(0, 1, 17, 0, 1, 15, 1, 2);
    add(1, 1, 18, 1, 0, -1, 0, 3);  // flush with 3 held and a concurrent push
    add(0, 0, 0, 0, 0, -1, 1, 0);
    add(0, 1, 19, 0, BYP, BYP ? 19 : -1, 1, 0);
    add(0, 0, 0, 1, 1, 19, 1, 1);
    add(0, 0, 0, 0, 0, -1, 1, 0);

    #1;
    chk("reset idv", 32'(id_valid_o), 32'd0);
    chk("reset inst", inst_o, NOP);
    chk("reset count", 32'(count_o), 32'd0);
    chk("reset ready", 32'(inst_ready_o), 32'd1);
    @(negedge clk); rst = 1'b0;

    foreach (tbl[i])
      begin
        drive(tbl[i].fl, tbl[i].v, tbl[i].k, tbl[i].rd);
        check_out($sformatf("row%0d", i), tbl[i].eidv, tbl[i].ek, tbl[i].erdy, tbl[i].ecnt);
      end

    // Empty buffer, beat presented with decode ready.
    drive(0, 1, 20, 1);
    check_out("byp0", BYP, BYP ? 20 : -1, 1, 0);
    drive(0, 0, 0, 0);
    check_out("byp1", !BYP, BYP ? -1 : 20, 1, BYP ? 0 : 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    check_out("byp2", 0, -1, 1, 0);

    // Reset asserted mid-stream with 3 entries held.
    drive(0, 1, 21, 0);
    drive(0, 1, 22, 0);
    drive(0, 1, 23, 0);
    drive(0, 0, 0, 0);
    check_out("pre_rst", 1, 21, 1, 3);
    rst = 1'b1;
    #1;
    check_out("mid_rst", 0, -1, 1, 0);
    flush_i = 1'b1;
    #1;
    chk("rst+flush ready", 32'(inst_ready_o), 32'd0);
    chk("rst+flush idv", 32'(id_valid_o), 32'd0);
    @(negedge clk); flush_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    drive(0, 0, 0, 1);
    check_out("post_rst", 0, -1, 1, 0);
    drive(0, 1, 24, 0);
    drive(0, 0, 0, 0);
    check_out("refetch", 1, 24, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
